// File: rtl/lifo_pkg.sv
// Shared definitions for the 8-deep byte LIFO and its drain controller.
package lifo_pkg;

  localparam int LIFO_DEPTH = 8;
  localparam int LIFO_DW    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_FIN     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ISSUE   = ST_ISSUE,
    CAPTURE = ST_CAPTURE,
    HOLD    = ST_HOLD,
    FIN     = ST_FIN
  } drain_state_e;

endpackage

// File: rtl/lifo_drain_ctrl.sv
// Pops up to COUNT bytes from the LIFO one at a time and forwards them over a
// valid/ready stream, flagging the final beat and any early underflow.
module lifo_drain_ctrl
  import lifo_pkg::*;
#(
  parameter int DW    = LIFO_DW,
  parameter int DEPTH = LIFO_DEPTH,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          lifo_empty,
  output logic          lifo_rd,
  input  logic [DW-1:0] lifo_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic          underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  drain_state_e  state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_last_q, m_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underflow_q, underflow_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    underflow_d = underflow_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          underflow_d = 1'b0;
          remaining_d = (count > DEPTH_C) ? DEPTH_C : count;
          state_d     = (count == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (lifo_empty) begin
          underflow_d = 1'b1;
          state_d     = FIN;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        m_data_d  = lifo_data;
        m_valid_d = 1'b1;
        m_last_d  = (remaining_q == ONE_C);
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_d   = 1'b0;
          m_last_d    = 1'b0;
          remaining_d = remaining_q - ONE_C;
          state_d     = (remaining_q == ONE_C) ? FIN : ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered against the state being entered so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  // The read strobe must see lifo_empty in the same cycle, so it cannot be registered.
  assign lifo_rd   = (state_q == ISSUE) && !lifo_empty;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Randomised scoreboard bench for lifo_drain_ctrl driving a behavioural 8-deep LIFO.
module tb_lifo_drain_ctrl;
  import lifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          lifo_empty;
  logic          lifo_rd;
  logic [DW-1:0] lifo_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          underflow;

  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          ready_rand = 1'b0;
  logic          ready_val = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   beat_exp[$];
  logic          done_uf_exp[$];
  int            done_rd_exp[$];
  logic [DW-1:0] ref_stack[$];

  always #5 clk = ~clk;

  lifo_drain_ctrl #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .lifo_empty(lifo_empty), .lifo_rd(lifo_rd), .lifo_data(lifo_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .underflow(underflow)
  );

  // Behavioural LIFO with a one-cycle read latency; shares the controller's reset.
  logic [DW-1:0] mem [DEPTH];
  logic [3:0]    sp;
  assign lifo_empty = (sp == 4'd0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= 4'd0;
      lifo_data <= '0;
    end else if (lifo_rd) begin
      lifo_data <= mem[3'(sp - 4'd1)];
      sp        <= sp - 4'd1;
    end else if (push_en && sp < 4'd8) begin
      mem[3'(sp)] <= push_data;
      sp          <= sp + 4'd1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    int  beat_idx = 0;
    int  done_idx = 0;
    int  rd_cnt = 0;
    logic prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        beat_idx = beat_exp.size();
        done_idx = done_uf_exp.size();
        rd_cnt   = 0;
        prev_rd  = 1'b0;
        continue;
      end
      if (lifo_rd) begin
        rd_cnt++;
        check_output("rd_adjacent", 32'(prev_rd), 32'd0);
      end
      prev_rd = lifo_rd;
      if (m_valid) begin
        if (beat_idx >= beat_exp.size()) begin
          check_output("unexpected_beat", 32'(m_valid), 32'd0);
        end else begin
          check_output("beat_data", 32'(m_data), 32'(beat_exp[beat_idx][DW-1:0]));
          check_output("beat_last", 32'(m_last), 32'(beat_exp[beat_idx][DW]));
          if (m_ready) beat_idx++;
        end
      end
      if (done) begin
        if (done_idx >= done_uf_exp.size()) begin
          check_output("unexpected_done", 32'(done), 32'd0);
        end else begin
          check_output("done_underflow", 32'(underflow), 32'(done_uf_exp[done_idx]));
          check_output("done_rd_count", 32'(rd_cnt), 32'(done_rd_exp[done_idx]));
          check_output("done_beats_left", 32'(beat_exp.size() - beat_idx), 32'd0);
          done_idx++;
        end
        rd_cnt = 0;
      end
    end
  endtask

  task automatic push_one(input logic [DW-1:0] b);
    @(posedge clk); #1;
    push_en   = 1'b1;
    push_data = b;
    ref_stack.push_back(b);
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  // Reference: pop min(n, DEPTH) from the top; a short stack yields only what it holds and no last.
  task automatic apply_stimulus(input int n, input bit inject_start, input int hold_cycles);
    int  k, nb, first_rd, first_v, done_at;
    bit  uf, had_data;
    k        = (n > DEPTH) ? DEPTH : n;
    uf       = (ref_stack.size() < k);
    nb       = uf ? ref_stack.size() : k;
    had_data = (ref_stack.size() > 0);
    for (int i = 0; i < nb; i++) begin
      logic [DW-1:0] b;
      b = ref_stack.pop_back();
      beat_exp.push_back({(!uf && i == nb - 1), b});
    end
    done_uf_exp.push_back(uf);
    done_rd_exp.push_back(nb);
    if (hold_cycles > 0) ready_val = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    count = CW'(n);
    @(posedge clk); #1;
    start    = 1'b0;
    first_rd = -1;
    first_v  = -1;
    done_at  = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (lifo_rd && first_rd < 0) first_rd = c;
      if (m_valid && first_v < 0) first_v = c;
      if (inject_start && c == 2) begin start = 1'b1; count = CW'(1); end
      if (inject_start && c == 3) start = 1'b0;
      if (hold_cycles > 0 && first_v > 0 && m_valid && !m_ready)
        check_output("no_rd_while_held", 32'(lifo_rd), 32'd0);
      if (hold_cycles > 0 && first_v > 0 && c == first_v + hold_cycles) ready_val = 1'b1;
      if (done) begin done_at = c; break; end
    end
    ready_val = 1'b1;
    if (done_at < 0) check_output("drain_timeout", 32'd0, 32'd1);
    if (n > 0 && had_data) check_output("start_to_rd", 32'(first_rd), 32'd1);
    if (nb > 0) check_output("start_to_valid", 32'(first_v), 32'd3);
    if (n == 0) check_output("cnt0_done_latency", 32'(done_at), 32'd1);
    if (n == 0) check_output("cnt0_no_rd", 32'(first_rd), 32'hffffffff);
  endtask

  task automatic reset_during_hold();
    int seen;
    push_one(8'h5a);
    push_one(8'ha5);
    done_uf_exp.push_back(1'b0);
    done_rd_exp.push_back(2);
    beat_exp.push_back({1'b0, ref_stack.pop_back()});
    beat_exp.push_back({1'b1, ref_stack.pop_back()});
    ready_val = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    count = CW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    check_output("hold_reached", 32'(seen), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_rst_valid", 32'(m_valid), 32'd0);
    check_output("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    ref_stack.delete();
    ready_val = 1'b1;
  endtask

  task automatic stimulus();
    repeat (3) @(negedge clk);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_valid", 32'(m_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_underflow", 32'(underflow), 32'd0);
    check_output("rst_lifo_rd", 32'(lifo_rd), 32'd0);
    check_output("rst_m_data", 32'(m_data), 32'd0);
    check_output("rst_m_last", 32'(m_last), 32'd0);
    #2;
    reset = 1'b1;

    push_one(8'hA1); push_one(8'hB2); push_one(8'hC3);
    apply_stimulus(3, 1'b0, 0);

    push_one(8'h11); push_one(8'h22);
    apply_stimulus(4, 1'b0, 0);

    push_one(8'h33); push_one(8'h44);
    apply_stimulus(2, 1'b0, 5);

    apply_stimulus(0, 1'b0, 0);

    for (int i = 0; i < DEPTH; i++) push_one(8'($urandom));
    apply_stimulus(12, 1'b0, 0);

    push_one(8'h71); push_one(8'h72); push_one(8'h73);
    apply_stimulus(3, 1'b1, 0);

    reset_during_hold();

    ready_rand = 1'b1;
    for (int d = 0; d < 200; d++) begin
      int np;
      np = $urandom_range(0, DEPTH - ref_stack.size());
      for (int i = 0; i < np; i++) push_one(8'($urandom));
      apply_stimulus($urandom_range(0, 12), 1'b0, 0);
    end
    ready_rand = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(posedge clk); #1;
          m_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        end
      end
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
